// File: rtl/sw_entry_capture_pkg.sv
// Shared constants and state encoding for the switch-entry capture path.
package sw_entry_capture_pkg;

    localparam int KEY_CAPTURE = 0;
    localparam int KEY_CLEAR   = 1;
    localparam int ENTRY_BYTES = 3;
    localparam int ENTRY_W     = ENTRY_BYTES * 8;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } cap_state_t;

endpackage

// File: rtl/sw_entry_capture_key_debounce.sv
// Single active-low key: 2-flop synchronizer, stability counter and press-edge strobe.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_n,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             sample;
    logic [CNT_W-1:0] cnt;

    assign sample = ~sync_p1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            cnt     <= '0;
            level   <= 1'b0;
            press   <= 1'b0;
        end else begin
            sync_p0 <= raw_n;
            sync_p1 <= sync_p0;
            press   <= 1'b0;
            if (sample == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                // Only the released->pressed toggle raises the strobe.
                cnt   <= '0;
                level <= ~level;
                press <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sw_entry_capture.sv
// Debounced key capture of the slide switches into a 3-byte shift buffer for the display path.
module sw_entry_capture
    import sw_entry_capture_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [7:0]          SW,
    input  logic [1:0]          KEY,
    output logic [ENTRY_W-1:0]  digits,
    output logic [1:0]          count,
    output logic                full,
    output logic                capture_pulse,
    output logic [1:0]          key_level
);

    logic [7:0] sw_p0;
    logic [7:0] sw_p1;
    logic [1:0] press;
    cap_state_t state;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'(ENTRY_BYTES)) ? c : c + 2'd1;
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key_debounce (
            .clk    (clk),
            .reset_n(reset_n),
            .raw_n  (KEY[k]),
            .level  (key_level[k]),
            .press  (press[k])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_p0 <= '0;
            sw_p1 <= '0;
        end else begin
            sw_p0 <= SW;
            sw_p1 <= sw_p0;
        end
    end

    assign full = (count == 2'(ENTRY_BYTES));

    // Clear takes priority over a capture arriving in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_EMPTY;
            digits        <= '0;
            count         <= '0;
            capture_pulse <= 1'b0;
        end else begin
            capture_pulse <= 1'b0;
            if (press[KEY_CLEAR]) begin
                state  <= ST_EMPTY;
                digits <= '0;
                count  <= '0;
            end else if (press[KEY_CAPTURE]) begin
                capture_pulse <= 1'b1;
                digits        <= {digits[ENTRY_W-9:0], sw_p1};
                case (state)
                    ST_EMPTY: begin
                        count <= 2'd1;
                        state <= ST_PARTIAL;
                    end
                    ST_PARTIAL: begin
                        count <= sat_inc(count);
                        state <= (sat_inc(count) == 2'(ENTRY_BYTES)) ? ST_FULL : ST_PARTIAL;
                    end
                    default: begin
                        count <= 2'(ENTRY_BYTES);
                        state <= ST_FULL;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sw_entry_capture.sv
// Scoreboard bench for sw_entry_capture with a short debounce window.
module tb_sw_entry_capture;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  SW;
    logic [1:0]  KEY;
    logic [23:0] digits;
    logic [1:0]  count;
    logic        full;
    logic        capture_pulse;
    logic [1:0]  key_level;

    typedef struct {
        logic [23:0] digits;
        logic [1:0]  count;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;
    int   pulses = 0;

    sw_entry_capture #(.DEBOUNCE_CYCLES(D)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .SW           (SW),
        .KEY          (KEY),
        .digits       (digits),
        .count        (count),
        .full         (full),
        .capture_pulse(capture_pulse),
        .key_level    (key_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every capture strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && capture_pulse === 1'b1) begin
            pulses++;
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("cap_digits", 32'(digits), 32'(e.digits));
                chk("cap_count", 32'(count), 32'(e.count));
                if (e.cyc >= 0) chk("cap_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Press keys in mask for hold cycles, then release and let the release debounce.
    task automatic press_keys(input logic [1:0] mask, input int hold);
        tick(1);
        KEY = KEY & ~mask;
        tick(hold);
        KEY = 2'b11;
        tick(2 * D + 4);
    endtask

    task automatic capture(input logic [7:0] val, input logic [23:0] exp_d, input logic [1:0] exp_c);
        SW = val;
        tick(3);
        sb.push_back('{exp_d, exp_c, -1});
        press_keys(2'b01, 20);
    endtask

    initial begin
        int k;
        logic saw_level;
        reset_n = 1'b0;
        SW = 8'h00;
        KEY = 2'b11;
        tick(3);
        reset_n = 1'b1;
        tick(2);
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_pulse", 32'(capture_pulse), 32'h0);
        chk("rst_key_level", 32'(key_level), 32'h0);

        // Single capture with latency check.
        SW = 8'hA5;
        tick(3);
        k = cyc;
        sb.push_back('{24'h0000A5, 2'd1, k + 7});
        KEY[0] = 1'b0;
        tick(10);
        chk("hold_key_level", 32'(key_level), 32'h1);
        tick(10);
        KEY[0] = 1'b1;
        tick(2 * D + 4);
        chk("single_digits", 32'(digits), 32'h0000A5);
        chk("single_count", 32'(count), 32'h1);
        chk("release_key_level", 32'(key_level), 32'h0);

        // Bounce shorter than the debounce window.
        saw_level = 1'b0;
        for (int i = 0; i < 16; i++) begin
            KEY[0] = (i % 4) >= 2;
            tick(1);
            if (key_level[0]) saw_level = 1'b1;
        end
        KEY[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (key_level[0]) saw_level = 1'b1;
        end
        chk("bounce_key_level", 32'(saw_level), 32'h0);
        chk("bounce_count", 32'(count), 32'h1);

        // Clear.
        press_keys(2'b10, 20);
        chk("clear_digits", 32'(digits), 32'h0);
        chk("clear_count", 32'(count), 32'h0);

        // Fill and overflow.
        capture(8'h11, 24'h000011, 2'd1);
        capture(8'h22, 24'h001122, 2'd2);
        chk("fill2_full", 32'(full), 32'h0);
        capture(8'h33, 24'h112233, 2'd3);
        chk("fill3_full", 32'(full), 32'h1);
        chk("fill3_digits", 32'(digits), 32'h112233);
        capture(8'h44, 24'h223344, 2'd3);
        chk("ovf_digits", 32'(digits), 32'h223344);
        chk("ovf_count", 32'(count), 32'h3);
        chk("ovf_full", 32'(full), 32'h1);
        chk("fill_pulses", 32'(pulses), 32'd5);

        // Simultaneous capture and clear from count 2.
        press_keys(2'b10, 20);
        capture(8'hAA, 24'h0000AA, 2'd1);
        capture(8'hBB, 24'h00AABB, 2'd2);
        SW = 8'hCC;
        press_keys(2'b11, 20);
        chk("simul_digits", 32'(digits), 32'h0);
        chk("simul_count", 32'(count), 32'h0);
        chk("simul_pulses", 32'(pulses), 32'd7);

        // Long hold with SW changing every cycle: value from 4 cycles after the press lands.
        k = cyc;
        sb.push_back('{24'h000064, 2'd1, k + 7});
        KEY[0] = 1'b0;
        for (int i = 0; i < 200; i++) begin
            SW = 8'(8'h60 + i);
            tick(1);
        end
        KEY[0] = 1'b1;
        tick(2 * D + 4);
        chk("hold_digits", 32'(digits), 32'h000064);
        chk("hold_pulses", 32'(pulses), 32'd8);

        // Reset mid-debounce with key still held, then press re-qualifies after release.
        SW = 8'h5C;
        KEY[0] = 1'b0;
        tick(4);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_digits", 32'(digits), 32'h0);
        chk("midrst_count", 32'(count), 32'h0);
        chk("midrst_full", 32'(full), 32'h0);
        chk("midrst_key_level", 32'(key_level), 32'h0);
        tick(5);
        chk("inrst_key_level", 32'(key_level), 32'h0);
        k = cyc;
        sb.push_back('{24'h00005C, 2'd1, k + 7});
        reset_n = 1'b1;
        tick(20);
        KEY[0] = 1'b1;
        tick(2 * D + 4);
        chk("postrst_count", 32'(count), 32'h1);
        chk("total_pulses", 32'(pulses), 32'd9);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
